// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Next-PC controller for the single-cycle core. Produces the next
//             PC value and PC write enable. Owns boot, stall, halt and
//             instruction-fetch timeout sequencing.
//  Ports    : clk, rst (async, active-high)
//             pc_q (current PC), imem_ready, hlt, br, br_reg, ccc, imm,
//             rs_val, flag_z/v/n                              -> inputs
//             pc_d, pc_wen (combinational)
//             taken, halted, fault (registered)               -> outputs
//  Options  : PC_SEQ_LINK_EN adds call/ret inputs and a registered link
//             output that holds the return address.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned WAIT_LIMIT = 16          // 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_q,
    input  logic        imem_ready,
    input  logic        hlt,
    input  logic        br,
    input  logic        br_reg,
    input  logic [2:0]  ccc,
    input  logic [8:0]  imm,
    input  logic [15:0] rs_val,
    input  logic        flag_z,
    input  logic        flag_v,
    input  logic        flag_n,
`ifdef PC_SEQ_LINK_EN
    input  logic        call,
    input  logic        ret,
    output logic [15:0] link,
`endif
    output logic [15:0] pc_d,
    output logic        pc_wen,
    output logic        taken,
    output logic        halted,
    output logic        fault
);

    localparam logic [7:0] c_WAIT_LIMIT = 8'(WAIT_LIMIT);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait_cnt;

    logic        w_cond;
    logic        w_decide;
    logic [15:0] w_seq;
    logic [15:0] w_rel;
    logic [7:0]  w_wait_next;

    // Condition-code evaluation against the ALU flags.
    always_comb begin
        w_cond = 1'b0;
        case (ccc)
            3'b000: w_cond = ~flag_z;
            3'b001: w_cond = flag_z;
            3'b010: w_cond = ~flag_z & ~flag_n;
            3'b011: w_cond = flag_n;
            3'b100: w_cond = flag_z | ~flag_n;
            3'b101: w_cond = flag_n | flag_z;
            3'b110: w_cond = flag_v;
            default: w_cond = 1'b1;
        endcase
    end

    // Sequential and PC-relative targets; word offset is sign-extended and
    // doubled into a byte offset. All sums wrap modulo 2^16.
    assign w_seq       = pc_q + 16'd2;
    assign w_rel       = w_seq + {{6{imm[8]}}, imm, 1'b0};
    assign w_decide    = (r_state == ST_RUN || r_state == ST_WAIT) && imem_ready;
    assign w_wait_next = r_wait_cnt + 8'd1;

    // Next-PC selection. pc_wen is forced low while rst is held so the PC
    // register is not written before boot actually begins.
    always_comb begin
        pc_d   = pc_q;
        pc_wen = 1'b0;
        if (!rst) begin
            if (r_state == ST_BOOT) begin
                pc_d   = RESET_PC;
                pc_wen = 1'b1;
            end else if (w_decide && !hlt) begin
                pc_wen = 1'b1;
`ifdef PC_SEQ_LINK_EN
                if (ret)
                    pc_d = link;
                else if (call)
                    pc_d = w_rel;
                else
`endif
                if (br && w_cond)
                    pc_d = br_reg ? rs_val : w_rel;
                else
                    pc_d = w_seq;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_wait_cnt <= 8'd0;
            taken      <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
`ifdef PC_SEQ_LINK_EN
            link       <= 16'h0000;
`endif
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN, ST_WAIT: begin
                    if (imem_ready) begin
                        r_wait_cnt <= 8'd0;
                        if (hlt) begin
                            r_state <= ST_HALT;
                            halted  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
`ifdef PC_SEQ_LINK_EN
                            if (ret) begin
                                taken <= 1'b0;
                            end else if (call) begin
                                taken <= 1'b0;
                                link  <= w_seq;
                            end else
`endif
                            taken <= br & w_cond;
                        end
                    end else begin
                        // Counter stops at the limit: FAULT is terminal.
                        r_wait_cnt <= w_wait_next;
                        if (w_wait_next == c_WAIT_LIMIT) begin
                            r_state <= ST_FAULT;
                            halted  <= 1'b1;
                            fault   <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_HALT:  r_state <= ST_HALT;
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_BOOT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed self-checking bench for pc_sequencer with
//             hand-computed expected values. Link tests are built only when
//             PC_SEQ_LINK_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_q;
    logic        imem_ready, hlt, br, br_reg;
    logic [2:0]  ccc;
    logic [8:0]  imm;
    logic [15:0] rs_val;
    logic        flag_z, flag_v, flag_n;
    logic [15:0] pc_d;
    logic        pc_wen, taken, halted, fault;
`ifdef PC_SEQ_LINK_EN
    logic        call, ret;
    logic [15:0] link;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .pc_q       (pc_q),
        .imem_ready (imem_ready),
        .hlt        (hlt),
        .br         (br),
        .br_reg     (br_reg),
        .ccc        (ccc),
        .imm        (imm),
        .rs_val     (rs_val),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_n     (flag_n),
`ifdef PC_SEQ_LINK_EN
        .call       (call),
        .ret        (ret),
        .link       (link),
`endif
        .pc_d       (pc_d),
        .pc_wen     (pc_wen),
        .taken      (taken),
        .halted     (halted),
        .fault      (fault)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        hlt = 1'b0; br = 1'b0; br_reg = 1'b0; ccc = 3'b000; imm = 9'h000;
        rs_val = 16'h0000; flag_z = 1'b0; flag_v = 1'b0; flag_n = 1'b0;
`ifdef PC_SEQ_LINK_EN
        call = 1'b0; ret = 1'b0;
`endif
    endtask

    // Reset pulse spanning a clock edge, released on a falling edge; the
    // cycle after release is BOOT.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("boot_wen", {15'd0, pc_wen}, 16'd1);
        chk("boot_pcd", pc_d, 16'h0000);
    endtask

    // {ccc, z, v, n, expected-taken}
    logic [6:0] cc_vec [6];

    initial begin
        cc_vec[0] = {3'b010, 1'b0, 1'b0, 1'b0, 1'b1};  // GT
        cc_vec[1] = {3'b011, 1'b0, 1'b0, 1'b0, 1'b0};  // LT, N=0
        cc_vec[2] = {3'b110, 1'b0, 1'b1, 1'b0, 1'b1};  // OV
        cc_vec[3] = {3'b000, 1'b1, 1'b0, 1'b0, 1'b0};  // NE, Z=1
        cc_vec[4] = {3'b100, 1'b0, 1'b0, 1'b1, 1'b0};  // GE, N=1
        cc_vec[5] = {3'b101, 1'b1, 1'b0, 1'b0, 1'b1};  // LE, Z=1

        rst = 1'b1;
        pc_q = 16'h0000;
        imem_ready = 1'b1;
        idle_inputs();

        // Reset state while rst is held.
        #12;
        chk("rst_wen", {15'd0, pc_wen}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_fault", {15'd0, fault}, 16'd0);
        chk("rst_taken", {15'd0, taken}, 16'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("boot_wen", {15'd0, pc_wen}, 16'd1);
        chk("boot_pcd", pc_d, 16'h0000);

        // Sequential flow and wraparound.
        @(negedge clk);
        pc_q = 16'h0010; #1;
        chk("seq_pcd", pc_d, 16'h0012);
        chk("seq_wen", {15'd0, pc_wen}, 16'd1);
        @(negedge clk);
        pc_q = 16'hFFFE; #1;
        chk("wrap_pcd", pc_d, 16'h0000);

        // EQ branch, negative offset.
        @(negedge clk);
        pc_q = 16'h0100; br = 1'b1; ccc = 3'b001; imm = 9'h1FE; flag_z = 1'b1; #1;
        chk("beq_t_pcd", pc_d, 16'h00FE);
        @(posedge clk); #1;
        chk("beq_t_taken", {15'd0, taken}, 16'd1);
        @(negedge clk);
        flag_z = 1'b0; #1;
        chk("beq_nt_pcd", pc_d, 16'h0102);
        @(posedge clk); #1;
        chk("beq_nt_taken", {15'd0, taken}, 16'd0);

        // Condition-code table, positive offset: target 0x0202 + 8.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pc_q = 16'h0200; br = 1'b1; br_reg = 1'b0; imm = 9'h004;
            ccc = cc_vec[i][6:4]; flag_z = cc_vec[i][3]; flag_v = cc_vec[i][2]; flag_n = cc_vec[i][1];
            #1;
            chk("cc_pcd", pc_d, cc_vec[i][0] ? 16'h020A : 16'h0202);
            @(posedge clk); #1;
            chk("cc_taken", {15'd0, taken}, {15'd0, cc_vec[i][0]});
        end

        // Register branch, always condition.
        @(negedge clk);
        idle_inputs();
        br = 1'b1; br_reg = 1'b1; ccc = 3'b111; rs_val = 16'h4000; pc_q = 16'h0300; #1;
        chk("br_reg_pcd", pc_d, 16'h4000);

        // Short stall: branch request ignored while not ready.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            imem_ready = 1'b0; #1;
            chk("stall_wen", {15'd0, pc_wen}, 16'd0);
            chk("stall_pcd", pc_d, 16'h0300);
        end
        @(negedge clk);
        idle_inputs();
        imem_ready = 1'b1; pc_q = 16'h0400; #1;
        chk("resume_wen", {15'd0, pc_wen}, 16'd1);
        chk("resume_pcd", pc_d, 16'h0402);
        @(posedge clk); #1;
        chk("resume_fault", {15'd0, fault}, 16'd0);

        // Long stall to timeout.
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            imem_ready = 1'b0;
            @(posedge clk); #1;
            if (i == 15) chk("to_15_fault", {15'd0, fault}, 16'd0);
            if (i == 16) begin
                chk("to_16_fault", {15'd0, fault}, 16'd1);
                chk("to_16_halted", {15'd0, halted}, 16'd1);
            end
        end
        @(negedge clk);
        imem_ready = 1'b1; #1;
        chk("fault_wen", {15'd0, pc_wen}, 16'd0);
        chk("fault_pcd", pc_d, 16'h0400);

        // Async reset out of FAULT.
        @(negedge clk);
        rst = 1'b1; #1;
        chk("rstf_fault", {15'd0, fault}, 16'd0);
        chk("rstf_halted", {15'd0, halted}, 16'd0);
        do_reset();

        // hlt has priority over br.
        @(negedge clk);
        pc_q = 16'h0500; hlt = 1'b1; br = 1'b1; ccc = 3'b111; #1;
        chk("hlt_wen", {15'd0, pc_wen}, 16'd0);
        chk("hlt_pcd", pc_d, 16'h0500);
        @(posedge clk); #1;
        chk("hlt_halted", {15'd0, halted}, 16'd1);
        chk("hlt_fault", {15'd0, fault}, 16'd0);
        @(negedge clk);
        idle_inputs(); #1;
        chk("halt_wen", {15'd0, pc_wen}, 16'd0);

        // Async reset out of HALT.
        @(negedge clk);
        rst = 1'b1; #1;
        chk("rsth_halted", {15'd0, halted}, 16'd0);
        do_reset();

`ifdef PC_SEQ_LINK_EN
        @(negedge clk);
        chk("link_rst", link, 16'h0000);
        pc_q = 16'h0020; call = 1'b1; imm = 9'h008; #1;
        chk("call_pcd", pc_d, 16'h0032);
        @(posedge clk); #1;
        chk("call_link", link, 16'h0022);
        @(negedge clk);
        call = 1'b0; ret = 1'b1; br = 1'b1; ccc = 3'b111; pc_q = 16'h0032; #1;
        chk("ret_pcd", pc_d, 16'h0022);
        @(negedge clk);
        idle_inputs();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
